// File: rtl/easyaxi_ar_arb.sv
// easyaxi_ar_arb: merges NUM_MST master AR channels onto one slave AR channel
// with round-robin arbitration and a one-deep output register. The granted
// master index is prepended to ARID so read responses can be routed back.
// Latency: master handshake to slave ARVALID is 1 cycle; 1 beat/cycle sustained.
// Backpressure: a stalled slave holds the register and all master ARREADYs low;
// the register frees and refills in the same cycle the slave accepts.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   enable           permits new grants (held beat drains regardless)
//   axi_mst_ar*      packed per-master AR channels, master i at [i*W +: W]
//   axi_slv_ar*      slave AR channel, ARID = {master index, master ARID}
//   ar_busy          output register holds a beat
module easyaxi_ar_arb #(
  parameter int NUM_MST    = 4,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   enable,
  input  logic [NUM_MST-1:0]                     axi_mst_arvalid,
  output logic [NUM_MST-1:0]                     axi_mst_arready,
  input  logic [NUM_MST*ID_WIDTH-1:0]            axi_mst_arid,
  input  logic [NUM_MST*ADDR_WIDTH-1:0]          axi_mst_araddr,
  output logic                                   axi_slv_arvalid,
  input  logic                                   axi_slv_arready,
  output logic [$clog2(NUM_MST)+ID_WIDTH-1:0]    axi_slv_arid,
  output logic [ADDR_WIDTH-1:0]                  axi_slv_araddr,
  output logic                                   ar_busy
);

  localparam int IDX_W = $clog2(NUM_MST);
  localparam int SID_W = IDX_W + ID_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MST - 1);
  localparam logic [IDX_W:0]   NUM_W    = (IDX_W + 1)'(NUM_MST);

  logic                  vld_q, vld_d;
  logic [SID_W-1:0]      id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;

  logic                  can_accept;
  logic                  arb_en;
  logic                  gnt_found;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  mst_hs;

  // Ready passes straight through: a beat leaving this cycle makes room.
  assign can_accept = ~vld_q | axi_slv_arready;
  assign arb_en     = enable & can_accept & ~rst;
  assign mst_hs     = arb_en & gnt_found;

  // Rotating search starting at ptr_q; the one-bit-wider sum lets the
  // wrap work for any NUM_MST, not just powers of two.
  always_comb begin : rr_search
    logic [IDX_W:0] cand;
    cand      = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W + 1)'(k);
      if (cand >= NUM_W) cand = cand - NUM_W;
      if (!gnt_found && axi_mst_arvalid[cand[IDX_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin : mst_ready
    axi_mst_arready = '0;
    if (mst_hs) axi_mst_arready[gnt_idx] = 1'b1;
  end

  always_comb begin : next_state
    vld_d  = vld_q;
    id_d   = id_q;
    addr_d = addr_q;
    ptr_d  = ptr_q;
    if (mst_hs) begin
      vld_d  = 1'b1;
      id_d   = {gnt_idx, axi_mst_arid[gnt_idx*ID_WIDTH +: ID_WIDTH]};
      addr_d = axi_mst_araddr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      ptr_d  = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end else if (axi_slv_arready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      id_q   <= '0;
      addr_q <= '0;
      ptr_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      id_q   <= id_d;
      addr_q <= addr_d;
      ptr_q  <= ptr_d;
    end
  end

  assign axi_slv_arvalid = vld_q;
  assign axi_slv_arid    = id_q;
  assign axi_slv_araddr  = addr_q;
  assign ar_busy         = vld_q;

endmodule

// File: doc/easyaxi_ar_arb.md
Name: easyaxi_ar_arb

Overview:
- Parametrised AXI read-address (AR) channel link, successor to the single-master/single-slave AR wiring.
- Merges NUM_MST master AR ports onto one slave AR port using round-robin arbitration.
- Widens ARID with the granted master index so the R-channel return path can route responses.
- Has a one-deep output register stage with full throughput. Sits between the masters and the slave, inside the top level.

Parameters:
- NUM_MST, 4, number of master AR ports (2..16).
- ID_WIDTH, 4, master-side ARID width.
- ADDR_WIDTH, 32, ARADDR width.
- IDX_W, derived localparam = clog2(NUM_MST), width of the master index prepended to the ID.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  permits new grants; the output stage drains regardless.
- axi_mst_arvalid  in  NUM_MST  per-master ARVALID.
- axi_mst_arready  out  NUM_MST  per-master ARREADY.
- axi_mst_arid  in  NUM_MST*ID_WIDTH  packed ARIDs; master i occupies bits [i*ID_WIDTH +: ID_WIDTH].
- axi_mst_araddr  in  NUM_MST*ADDR_WIDTH  packed ARADDRs, same packing.
- axi_slv_arvalid  out  1  slave ARVALID.
- axi_slv_arready  in  1  slave ARREADY.
- axi_slv_arid  out  IDX_W+ID_WIDTH  {master index, master ARID}.
- axi_slv_araddr  out  ADDR_WIDTH  slave ARADDR.
- ar_busy  out  1  high while the output register holds a beat.

Behaviour:
- Reset (rst=1 at a clk edge):
  - axi_slv_arvalid=0, ar_busy=0, axi_slv_arid=0, axi_slv_araddr=0.
  - Round-robin pointer = 0.
  - axi_mst_arready=0 while rst=1.
  - Reset mid-transfer discards the held beat.
- Output register:
  - can_accept = ~axi_slv_arvalid | axi_slv_arready (combinational; ready path passes through).
  - Slave handshake (arvalid & arready) frees the register in the same cycle it is refilled, giving 1 beat/cycle.
- Arbitration (combinational, each cycle):
  - If enable & can_accept & ~rst, grant the first i with axi_mst_arvalid[i]=1, searching ptr, ptr+1, … wrapping modulo NUM_MST.
  - axi_mst_arready is one-hot at the granted index, otherwise all zero.
  - No requests means no grant.
- Master handshake on index g:
  - Next cycle: axi_slv_arvalid=1, axi_slv_araddr=araddr[g], axi_slv_arid={g[IDX_W-1:0], arid[g]}.
  - ptr <= (g==NUM_MST-1) ? 0 : g+1.
  - Latency master→slave is exactly 1 cycle.
- Hold rules:
  - While axi_slv_arvalid=1 and axi_slv_arready=0, the slave outputs are held stable and all axi_mst_arready=0.
  - Pointer unchanged in any cycle without a master handshake.
- Slave handshake with no new grant: axi_slv_arvalid <= 0 next cycle.
- enable=0:
  - No new grants; a held beat is still presented until accepted.
  - Re-asserting enable resumes from the stored ptr.
- Fairness: a continuously requesting master waits at most NUM_MST-1 grants.
- ar_busy equals axi_slv_arvalid.
- Master-side inputs of non-granted masters are ignored. The block assumes masters keep ARVALID/ARID/ARADDR stable until ARREADY, per AXI.

Test Plan:
- Reset release, master 0 valid, ARID=0x3, ARADDR=0x1000, slave ready=1:
  - mst_arready=4'b0001 in cycle 0.
  - Next cycle slv_arvalid=1, slv_arid=6'h03, slv_araddr=0x1000.
- All 4 masters valid continuously, slave ready=1 → grants cycle 0,1,2,3,0,… one per cycle; slv_arid[5:4] follows 0,1,2,3,0.
- Master 2 valid, slave ready=0 for 3 cycles after the beat lands:
  - slv outputs stable with slv_arid[5:4]=2.
  - All mst_arready=0 until slave ready, then a new grant occurs in the same cycle as slave acceptance.
- ptr=3 with only masters 1 and 3 requesting → master 3 granted first, then master 1 (wrap-around).
- enable=0 with a beat held → beat drains on slave ready, no new grant while masters 0..3 are valid; enable=1 → grant from saved ptr.
- rst=1 asserted while slv_arvalid=1 and the slave is stalling → next cycle slv_arvalid=0, ptr=0; after release master 0 is granted first.
